// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared defines for the MEM-stage load/store unit: ALU op
//               codes for loads/stores, bus byte-select constants and small
//               decode helpers used by mem_lsu and mem_load_align.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    localparam int unsigned ALUOP_W = 8;

    // ALU op codes carried in the EX/MEM register
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    // Bus byte lanes, big-endian: lane 0 is bits 31:24
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_B0   = 4'b1000;
    localparam logic [3:0] SEL_B1   = 4'b0100;
    localparam logic [3:0] SEL_B2   = 4'b0010;
    localparam logic [3:0] SEL_B3   = 4'b0001;
    localparam logic [3:0] SEL_HI   = 4'b1100;
    localparam logic [3:0] SEL_LO   = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    function automatic logic op_is_load(input logic [ALUOP_W-1:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic op_is_store(input logic [ALUOP_W-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic op_is_byte(input logic [ALUOP_W-1:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_SB_OP);
    endfunction

    function automatic logic op_is_half(input logic [ALUOP_W-1:0] op);
        return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
    endfunction

    function automatic logic op_is_word(input logic [ALUOP_W-1:0] op);
        return (op == EXE_LW_OP) || (op == EXE_SW_OP);
    endfunction

    // Byte-lane select for an access; halfwords only look at addr[1]
    function automatic logic [3:0] bus_sel(input logic [ALUOP_W-1:0] op,
                                           input logic [1:0]         a);
        logic [3:0] sel;
        sel = SEL_NONE;
        if (op_is_byte(op)) begin
            case (a)
                2'b00:   sel = SEL_B0;
                2'b01:   sel = SEL_B1;
                2'b10:   sel = SEL_B2;
                default: sel = SEL_B3;
            endcase
        end else if (op_is_half(op)) begin
            sel = a[1] ? SEL_LO : SEL_HI;
        end else if (op_is_word(op)) begin
            sel = SEL_WORD;
        end
        return sel;
    endfunction

    function automatic logic addr_misaligned(input logic [ALUOP_W-1:0] op,
                                             input logic [1:0]         a);
        return (op_is_half(op) && a[0]) || (op_is_word(op) && (a != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load formatter. Picks the addressed byte or
//               halfword out of a big-endian bus word and sign/zero-extends
//               it according to the load op.
// Ports       : op_i    - load op code
//               addr_i  - low two address bits
//               word_i  - raw bus read word
//               data_o  - formatted 32-bit load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_lsu_pkg::*;
(
    input  logic [ALUOP_W-1:0] op_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        word_i,
    output logic [31:0]        data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'b00:   byte_sel = word_i[31:24];
            2'b01:   byte_sel = word_i[23:16];
            2'b10:   byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = addr_i[1] ? word_i[15:0] : word_i[31:16];
    end

    always_comb begin
        case (op_i)
            EXE_LB_OP:  data_o = {{24{byte_sel[7]}}, byte_sel};
            EXE_LBU_OP: data_o = {24'h0, byte_sel};
            EXE_LH_OP:  data_o = {{16{half_sel[15]}}, half_sel};
            EXE_LHU_OP: data_o = {16'h0, half_sel};
            default:    data_o = word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : MEM-stage load/store unit. Non-memory ops pass straight
//               through; loads/stores issue one registered bus request,
//               stall the pipeline until the one-cycle ack and, if the
//               stage is held by CTRL, keep the result in a buffer.
// Ports       : clk/rst           - clock, async active-low reset
//               aluop_i..whilo_i  - EX/MEM register contents
//               stall_i/stallreq_o- CTRL stall vector (bit 4) / request
//               bus_*             - registered data bus request + response
//               wd_o..whilo_o     - results to MEM/WB
//               excp_ad*_o        - load/store address-error flags
// Config      : MEM_ADDR_EXC_EN   - when defined, misaligned half/word
//                                   accesses raise an address error instead
//                                   of going to the bus
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        reg2_i,
    input  logic [4:0]         wd_i,
    input  logic               wreg_i,
    input  logic [31:0]        wdata_i,
    input  logic [31:0]        hi_i,
    input  logic [31:0]        lo_i,
    input  logic               whilo_i,
    input  logic [5:0]         stall_i,
    output logic               stallreq_o,
    output logic               bus_req_o,
    output logic               bus_we_o,
    output logic [31:0]        bus_addr_o,
    output logic [31:0]        bus_data_o,
    output logic [3:0]         bus_sel_o,
    input  logic [31:0]        bus_data_i,
    input  logic               bus_ack_i,
    output logic [4:0]         wd_o,
    output logic               wreg_o,
    output logic [31:0]        wdata_o,
    output logic [31:0]        hi_o,
    output logic [31:0]        lo_o,
    output logic               whilo_o,
    output logic               excp_adel_o,
    output logic               excp_ades_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        bus_req_q, bus_we_q;
    logic [31:0] bus_addr_q, bus_data_q, buf_q;
    logic [3:0]  bus_sel_q;

    logic        is_load, is_store, addr_err, mem_go;
    logic        issue, complete;
    logic [31:0] load_data, store_word, ack_result;

    // Only bit 4 of the CTRL vector concerns this stage
    logic        unused_stall;
    assign unused_stall = ^{stall_i[5], stall_i[3:0]};

    assign is_load  = op_is_load(aluop_i);
    assign is_store = op_is_store(aluop_i);

`ifdef MEM_ADDR_EXC_EN
    assign addr_err    = (is_load || is_store) && addr_misaligned(aluop_i, addr_i[1:0]);
    // Flags only make sense while the op is sitting in IDLE; a faulting op
    // never leaves IDLE, so qualifying with the state is purely defensive.
    assign excp_adel_o = (state_q == S_IDLE) && addr_err && is_load;
    assign excp_ades_o = (state_q == S_IDLE) && addr_err && is_store;
`else
    assign addr_err    = 1'b0;
    assign excp_adel_o = 1'b0;
    assign excp_ades_o = 1'b0;
`endif

    assign mem_go   = (is_load || is_store) && !addr_err;
    assign issue    = (state_q == S_IDLE) && mem_go;
    assign complete = (state_q == S_BUSY) && bus_ack_i;

    mem_load_align u_align (
        .op_i   (aluop_i),
        .addr_i (addr_i[1:0]),
        .word_i (bus_data_i),
        .data_o (load_data)
    );

    // Store data is replicated across all lanes; bus_sel picks the live ones
    always_comb begin
        if (op_is_byte(aluop_i)) begin
            store_word = {4{reg2_i[7:0]}};
        end else if (op_is_half(aluop_i)) begin
            store_word = {2{reg2_i[15:0]}};
        end else begin
            store_word = reg2_i;
        end
    end

    assign ack_result = is_load ? load_data : wdata_i;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (mem_go) state_d = S_BUSY;
            S_BUSY: if (bus_ack_i) state_d = stall_i[4] ? S_HOLD : S_IDLE;
            S_HOLD: if (!stall_i[4]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        case (state_q)
            S_IDLE: begin
                stallreq_o = mem_go;
                if (addr_err) wreg_o = 1'b0;
            end
            S_BUSY: begin
                if (bus_ack_i) wdata_o = ack_result;
                else           stallreq_o = 1'b1;
            end
            S_HOLD: wdata_o = buf_q;
            default: ;
        endcase
    end

    // ------------------------------------------------ bus request + buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= 32'h0;
            bus_data_q <= 32'h0;
            bus_sel_q  <= SEL_NONE;
            buf_q      <= 32'h0;
        end else if (issue) begin
            bus_req_q  <= 1'b1;
            bus_we_q   <= is_store;
            bus_addr_q <= {addr_i[31:2], 2'b00};
            bus_data_q <= is_store ? store_word : 32'h0;
            bus_sel_q  <= bus_sel(aluop_i, addr_i[1:0]);
        end else if (complete) begin
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            buf_q      <= ack_result;
        end
    end

    assign bus_req_o  = bus_req_q;
    assign bus_we_o   = bus_we_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_data_o = bus_data_q;
    assign bus_sel_o  = bus_sel_q;

    assign wd_o    = wd_i;
    assign hi_o    = hi_i;
    assign lo_o    = lo_i;
    assign whilo_o = whilo_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu. A transaction-level model
//               predicts every output on every falling edge; directed
//               vectors add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  aluop_i = EXE_NOP_OP;
    logic [31:0] addr_i = 32'h0, reg2_i = 32'h0, wdata_i = 32'h0;
    logic [31:0] hi_i = 32'h0, lo_i = 32'h0, bus_data_i = 32'h0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0, whilo_i = 1'b0, bus_ack_i = 1'b0;
    logic [5:0]  stall_i = 6'd0;
    logic        stallreq_o, bus_req_o, bus_we_o, wreg_o, whilo_o;
    logic        excp_adel_o, excp_ades_o;
    logic [31:0] bus_addr_o, bus_data_o, wdata_o, hi_o, lo_o;
    logic [3:0]  bus_sel_o;
    logic [4:0]  wd_o;

    mem_lsu dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .addr_i(addr_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i),
        .whilo_i(whilo_i), .stall_i(stall_i), .stallreq_o(stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_data_o(bus_data_o), .bus_sel_o(bus_sel_o), .bus_data_i(bus_data_i),
        .bus_ack_i(bus_ack_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .excp_adel_o(excp_adel_o), .excp_ades_o(excp_ades_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int stall_cnt = 0;
    int req_cnt = 0;

`ifdef MEM_ADDR_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------- reference model
    function automatic bit m_ld(input logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
               op == EXE_LHU_OP || op == EXE_LW_OP;
    endfunction
    function automatic bit m_st(input logic [7:0] op);
        return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
    endfunction
    function automatic int m_size(input logic [7:0] op);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        return 4;
    endfunction
    function automatic bit m_err(input logic [7:0] op, input logic [31:0] a);
        int sz;
        sz = m_size(op);
        return EXC_EN && (m_ld(op) || m_st(op)) && (sz > 1) && ((a % sz) != 0);
    endfunction
    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
        int sz, off;
        logic [31:0] v;
        sz  = m_size(op);
        off = (sz == 4) ? 0 : (int'(a % 4) / sz) * sz;       // byte offset of field
        v   = w >> (8 * (4 - sz - off));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (op == EXE_LB_OP && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (op == EXE_LH_OP && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction
    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
        int sz, off;
        logic [3:0] full;
        sz   = m_size(op);
        off  = (sz == 4) ? 0 : (int'(a % 4) / sz) * sz;
        full = (sz == 1) ? 4'b1000 : (sz == 2) ? 4'b1100 : 4'b1111;
        return full >> off;
    endfunction
    function automatic logic [31:0] m_sdata(input logic [7:0] op, input logic [31:0] r);
        int sz;
        sz = m_size(op);
        if (sz == 1) return (r & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (r & 32'hFFFF) * 32'h0001_0001;
        return r;
    endfunction

    bit          m_out = 0, m_hold = 0, m_req = 0, m_we = 0;
    logic [31:0] m_buf = 0, m_addr = 0, m_data = 0;
    logic [3:0]  m_bsel = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out <= 0; m_hold <= 0; m_req <= 0; m_we <= 0;
            m_buf <= 0; m_addr <= 0; m_data <= 0; m_bsel <= 0;
        end else if (m_hold) begin
            if (!stall_i[4]) m_hold <= 0;
        end else if (m_out) begin
            if (bus_ack_i) begin
                m_out  <= 0;
                m_req  <= 0;
                m_we   <= 0;
                m_buf  <= m_ld(aluop_i) ? m_load(aluop_i, addr_i, bus_data_i) : wdata_i;
                m_hold <= stall_i[4];
            end
        end else if ((m_ld(aluop_i) || m_st(aluop_i)) && !m_err(aluop_i, addr_i)) begin
            m_out  <= 1;
            m_req  <= 1;
            m_we   <= m_st(aluop_i);
            m_addr <= addr_i - (addr_i % 4);
            m_bsel <= m_sel(aluop_i, addr_i);
            m_data <= m_st(aluop_i) ? m_sdata(aluop_i, reg2_i) : 32'h0;
        end
    end

    // Compare process: every falling edge
    bit prev_req = 0;
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit          idle, mem, err;
                logic [31:0] e_wd;
                idle = !m_out && !m_hold;
                mem  = m_ld(aluop_i) || m_st(aluop_i);
                err  = m_err(aluop_i, addr_i);
                if (m_hold) e_wd = m_buf;
                else if (m_out && bus_ack_i)
                    e_wd = m_ld(aluop_i) ? m_load(aluop_i, addr_i, bus_data_i) : wdata_i;
                else e_wd = wdata_i;
                chk("stallreq", {31'h0, stallreq_o},
                    {31'h0, m_out ? !bus_ack_i : (idle && mem && !err)});
                chk("bus_req", {31'h0, bus_req_o}, {31'h0, m_req});
                chk("bus_we", {31'h0, bus_we_o}, {31'h0, m_we});
                chk("wdata", wdata_o, e_wd);
                chk("wreg", {31'h0, wreg_o}, {31'h0, (idle && err) ? 1'b0 : wreg_i});
                chk("wd", {27'h0, wd_o}, {27'h0, wd_i});
                chk("hi", hi_o, hi_i);
                chk("lo", lo_o, lo_i);
                chk("whilo", {31'h0, whilo_o}, {31'h0, whilo_i});
                chk("adel", {31'h0, excp_adel_o}, {31'h0, idle && err && m_ld(aluop_i)});
                chk("ades", {31'h0, excp_ades_o}, {31'h0, idle && err && m_st(aluop_i)});
                if (m_req) begin
                    chk("bus_addr", bus_addr_o, m_addr);
                    chk("bus_sel", {28'h0, bus_sel_o}, {28'h0, m_bsel});
                    chk("bus_data", bus_data_o, m_data);
                end
            end
            if (stallreq_o) stall_cnt++;
            if (bus_req_o && !prev_req) req_cnt++;
            prev_req = bus_req_o;
        end
    end

    // ----------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2);
        aluop_i = op;
        addr_i  = a;
        reg2_i  = r2;
        wreg_i  = m_ld(op) || !m_st(op);
        wdata_i = 32'h0BAD_F00D;
    endtask

    task automatic do_mem(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] r2, input logic [31:0] word,
                          input int ack_wait, input int hold, input logic [31:0] exp);
        drive(op, a, r2);
        step();
        repeat (ack_wait) step();
        bus_ack_i  = 1'b1;
        bus_data_i = word;
        stall_i    = (hold > 0) ? 6'b010000 : 6'b000000;
        sample();
        chk(name, wdata_o, exp);
        step();
        bus_ack_i  = 1'b0;
        bus_data_i = $urandom;
        if (hold > 0) begin
            repeat (hold) step();
            stall_i = 6'b000000;
            step();
        end
        aluop_i = EXE_NOP_OP;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] word;
        int          ack_wait;
        int          hold;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int s0, r0;
        vecs[0] = '{"lbu_a1",   EXE_LBU_OP, 32'h201, 32'h0,         32'h11AA_3380, 0, 0, 32'h0000_00AA};
        vecs[1] = '{"lh_a0",    EXE_LH_OP,  32'h300, 32'h0,         32'h8001_2345, 1, 0, 32'hFFFF_8001};
        vecs[2] = '{"lhu_a2",   EXE_LHU_OP, 32'h302, 32'h0,         32'h1234_F00D, 0, 1, 32'h0000_F00D};
        vecs[3] = '{"lb_a0",    EXE_LB_OP,  32'h400, 32'h0,         32'h7F00_1122, 0, 0, 32'h0000_007F};
        vecs[4] = '{"lb_a2",    EXE_LB_OP,  32'h402, 32'h0,         32'h0011_A022, 0, 0, 32'hFFFF_FFA0};
        vecs[5] = '{"lw_a0",    EXE_LW_OP,  32'h500, 32'h0,         32'h89AB_CDEF, 1, 0, 32'h89AB_CDEF};
        vecs[6] = '{"sb_a3",    EXE_SB_OP,  32'h603, 32'h1234_5655, 32'hFFFF_FFFF, 0, 0, 32'h0BAD_F00D};
        vecs[7] = '{"sw_a4",    EXE_SW_OP,  32'h704, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 0, 1, 32'h0BAD_F00D};

        // Reset state
        step();
        sample();
        chk("rst_req", {31'h0, bus_req_o}, 32'h0);
        chk("rst_we", {31'h0, bus_we_o}, 32'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_data", bus_data_o, 32'h0);
        chk("rst_sel", {28'h0, bus_sel_o}, 32'h0);
        step();
        rst = 1'b1;
        step();

        // ADD passthrough; stray ack in IDLE ignored
        aluop_i = EXE_ADD_OP; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
        hi_i = 32'hAAAA_0001; lo_i = 32'h5555_0002; whilo_i = 1'b1; bus_ack_i = 1'b1;
        sample();
        chk("add_wd", {27'h0, wd_o}, 32'd5);
        chk("add_wdata", wdata_o, 32'h1234);
        chk("add_whilo", {31'h0, whilo_o}, 32'd1);
        chk("add_stall", {31'h0, stallreq_o}, 32'd0);
        step();
        bus_ack_i = 1'b0;
        sample();
        chk("add_noreq", {31'h0, bus_req_o}, 32'd0);
        step();

        // LB addr 3, ack on the first BUSY cycle
        s0 = stall_cnt;
        drive(EXE_LB_OP, 32'h3, 32'h0);
        sample();
        chk("lb_stall_idle", {31'h0, stallreq_o}, 32'd1);
        step();
        bus_ack_i = 1'b1; bus_data_i = 32'h1122_3380;
        sample();
        chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
        chk("lb_stall_ack", {31'h0, stallreq_o}, 32'd0);
        chk("lb_req", {31'h0, bus_req_o}, 32'd1);
        step();
        bus_ack_i = 1'b0; aluop_i = EXE_NOP_OP;
        sample();
        chk("lb_stall_cycles", stall_cnt - s0, 32'd1);
        chk("lb_req_drop", {31'h0, bus_req_o}, 32'd0);
        step();

        // SH addr 0x102
        drive(EXE_SH_OP, 32'h102, 32'h0000_BEEF);
        step();
        sample();
        chk("sh_addr", bus_addr_o, 32'h0000_0100);
        chk("sh_sel", {28'h0, bus_sel_o}, 32'h3);
        chk("sh_data", bus_data_o, 32'hBEEF_BEEF);
        chk("sh_we", {31'h0, bus_we_o}, 32'd1);
        step();
        bus_ack_i = 1'b1;
        step();
        bus_ack_i = 1'b0; aluop_i = EXE_NOP_OP;
        step();

        // LW with delayed ack, stage held for two cycles after ack
        r0 = req_cnt;
        drive(EXE_LW_OP, 32'h40, 32'h0);
        step();
        step();
        step();
        bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_F00D; stall_i = 6'b010000;
        sample();
        chk("lw_ack_wdata", wdata_o, 32'hCAFE_F00D);
        step();
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        sample();
        chk("lw_hold1_wdata", wdata_o, 32'hCAFE_F00D);
        chk("lw_hold1_stall", {31'h0, stallreq_o}, 32'd0);
        step();
        bus_ack_i = 1'b1;
        sample();
        chk("lw_hold2_wdata", wdata_o, 32'hCAFE_F00D);
        step();
        bus_ack_i = 1'b0; stall_i = 6'b000000;
        sample();
        chk("lw_hold3_wdata", wdata_o, 32'hCAFE_F00D);
        step();
        aluop_i = EXE_NOP_OP;
        sample();
        chk("lw_one_req", req_cnt - r0, 32'd1);
        chk("lw_idle_stall", {31'h0, stallreq_o}, 32'd0);
        step();

        // Table of further load/store patterns
        foreach (vecs[i]) begin
            do_mem(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].word,
                   vecs[i].ack_wait, vecs[i].hold, vecs[i].exp);
            step();
        end

        // Misaligned word load
        r0 = req_cnt;
`ifdef MEM_ADDR_EXC_EN
        drive(EXE_LW_OP, 32'h2, 32'h0);
        sample();
        chk("mis_adel", {31'h0, excp_adel_o}, 32'd1);
        chk("mis_wreg", {31'h0, wreg_o}, 32'd0);
        chk("mis_stall", {31'h0, stallreq_o}, 32'd0);
        step();
        sample();
        chk("mis_noreq", {31'h0, bus_req_o}, 32'd0);
        step();
        drive(EXE_SH_OP, 32'h101, 32'h1234);
        sample();
        chk("mis_ades", {31'h0, excp_ades_o}, 32'd1);
        step();
        aluop_i = EXE_NOP_OP;
        sample();
        chk("mis_no_reqs", req_cnt - r0, 32'd0);
        step();
`else
        drive(EXE_LW_OP, 32'h2, 32'h0);
        step();
        sample();
        chk("mis_addr", bus_addr_o, 32'h0);
        chk("mis_adel_tied", {31'h0, excp_adel_o}, 32'd0);
        step();
        bus_ack_i = 1'b1; bus_data_i = 32'h1357_2468;
        sample();
        chk("mis_wdata", wdata_o, 32'h1357_2468);
        step();
        bus_ack_i = 1'b0; aluop_i = EXE_NOP_OP;
        step();
`endif

        // Reset while BUSY, then an ack after release
        drive(EXE_LW_OP, 32'h80, 32'h0);
        step();
        #1 rst = 1'b0;
        #1;
        chk("rst_busy_req", {31'h0, bus_req_o}, 32'd0);
        step();
        aluop_i = EXE_NOP_OP;
        step();
        rst = 1'b1;
        r0 = req_cnt;
        step();
        bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF;
        sample();
        chk("rst_ack_req", {31'h0, bus_req_o}, 32'd0);
        chk("rst_ack_stall", {31'h0, stallreq_o}, 32'd0);
        step();
        bus_ack_i = 1'b0;
        sample();
        chk("rst_no_retry", req_cnt - r0, 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 clk  in  1  sole clock; all state changes on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low; asserted level 0 forces reset state immediately.
REQ-003 aluop_i  in  8  EX/MEM op code; load/store codes are in the shared defines file.
REQ-004 addr_i  in  32 effective address; reg2_i  in  32  store data.
REQ-005 wd_i  in  5, wreg_i  in  1, wdata_i  in  32  destination register, write enable, ALU result.
REQ-006 hi_i, lo_i  in  32, whilo_i  in  1  HILO write from EX/MEM.
REQ-007 stall_i  in  6  pipeline stall vector from CTRL; bit 4 stalls this stage.
REQ-008 stallreq_o  out  1  stall request to CTRL.
REQ-009 bus_req_o, bus_we_o  out  1; bus_addr_o, bus_data_o  out  32; bus_sel_o  out  4  data bus request, all registered.
REQ-010 bus_data_i  in  32, bus_ack_i  in  1  read data and one-cycle completion strobe.
REQ-011 wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o  out  same widths  results to the MEM/WB register.
REQ-012 excp_adel_o, excp_ades_o  out  1  load/store address-error flags.

Function
REQ-013 FSM states: IDLE, BUSY, HOLD.
REQ-014 Non-memory op in IDLE: all result outputs equal inputs combinationally; stallreq_o = 0; no bus activity.
REQ-015 IDLE with memory op: stallreq_o = 1 combinationally; at next edge bus_req_o <= 1, addr/sel/we/data registered, state <= BUSY.
REQ-016 BUSY, bus_ack_i = 0: stallreq_o = 1; bus outputs hold.
REQ-017 BUSY, bus_ack_i = 1: stallreq_o = 0 same cycle; wdata_o = formatted bus_data_i for loads, wdata_i for stores; at edge bus_req_o <= 0, formatted data captured into buffer, state <= HOLD if stall_i[4] = 1, otherwise IDLE.
REQ-018 HOLD: stallreq_o = 0; wdata_o from buffer; no new request; at edge with stall_i[4] = 0, state <= IDLE.
REQ-019 Minimum memory-op latency 2 cycles (issue, ack); every bus_ack_i not in BUSY is ignored.
REQ-020 Byte order big-endian: addr[1:0] = 00 selects bits 31:24, sel 1000.
REQ-021 Loads: LB/LBU sign/zero-extend the selected byte; LH/LHU the selected half (addr[1] = 0 -> bits 31:16); LW the full word.
REQ-022 Stores: SB replicates reg2_i[7:0] to all lanes, one-hot sel; SH replicates halfword, sel 1100/0011; SW sel 1111.
REQ-023 Stores: wreg_o = wreg_i; bus_we_o = 1 only for stores; bus_addr_o = {addr_i[31:2], 2'b00}.
REQ-024 hi_o/lo_o/whilo_o pass through combinationally in all states.

Reset
REQ-025 rst = 0: state IDLE, bus_req_o/bus_we_o 0, bus_addr_o/bus_data_o 0, bus_sel_o 0000, buffer 0.
REQ-026 Reset in BUSY or HOLD abandons the transaction; bus_req_o drops asynchronously; no retry after release.

Configuration
REQ-027 Macro MEM_ADDR_EXC_EN defined: misaligned LH/LHU/SH (addr[0] = 1) or LW/SW (addr[1:0] != 00) issue no bus request, stay IDLE, stallreq_o = 0, wreg_o = 0, excp_adel_o (loads) or excp_ades_o (stores) = 1 combinationally.
REQ-028 Macro undefined: both excp ports tied 0; misaligned halfword/word accesses proceed with the low address bits ignored.

Structure
REQ-029 Load/store op codes and byte-select constants live in the shared defines file; FSM encodings stay local.
REQ-030 Load extraction/extension is a combinational sub-module mem_load_align (inputs op, addr[1:0], bus word; output 32-bit result).

Verification
REQ-031 LB addr 0x0000_0003, bus word 0x1122_3380, ack next cycle -> wdata_o 0xFFFF_FF80, stallreq_o 1 for exactly 1 cycle.
REQ-032 SH addr 0x0000_0102, reg2 0x0000_BEEF -> bus_addr_o 0x0000_0100, bus_sel_o 0011, bus_data_o 0xBEEF_BEEF, bus_we_o 1.
REQ-033 LW, ack delayed 3 cycles, stall_i[4] = 1 at ack and 2 cycles after -> HOLD, wdata_o stable, one bus request only.
REQ-034 rst to 0 in BUSY, then ack pulse after release -> bus_req_o 0 immediately, state IDLE, ack ignored.
REQ-035 MEM_ADDR_EXC_EN defined, LW addr 0x0000_0002 -> excp_adel_o 1, bus_req_o stays 0, wreg_o 0; undefined -> normal read of 0x0000_0000.
REQ-036 ADD op (wd 5, wdata 0x1234, whilo 1) -> outputs equal inputs same cycle, stallreq_o 0.
